// File: rtl/wb_timer.sv
// rtl/wb_timer.sv - Wishbone prescaled down-counter timer with auto-reload, PWM and overflow strobe
module wb_timer #(
    parameter int          WIDTH    = 24,
    parameter logic [11:0] BASE     = 12'h000,
    parameter int          PRE_BITS = 8
) (
    input  logic        clk,
    input  logic        arst,
    input  logic [14:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic        irq_o,
    output logic        pwm_o
);

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_RELOAD  = 3'd1;
    localparam logic [2:0] OFF_COUNT   = 3'd2;
    localparam logic [2:0] OFF_COMPARE = 3'd3;
    localparam logic [2:0] OFF_STATUS  = 3'd4;

    logic                r_ack;
    logic [31:0]         r_dat;
    logic                r_irq;
    logic                r_pwm;
    logic                r_en;
    logic                r_ar;
    logic                r_ie;
    logic [PRE_BITS-1:0] r_prescale;
    logic [PRE_BITS-1:0] r_pre;
    logic [WIDTH-1:0]    r_reload;
    logic [WIDTH-1:0]    r_count;
    logic [WIDTH-1:0]    r_compare;
    logic                r_ovf;

    logic                w_sel;
    logic                w_acc;
    logic                w_wr;
    logic                w_wr_ctrl;
    logic                w_wr_reload;
    logic                w_wr_count;
    logic                w_wr_compare;
    logic                w_wr_status;
    logic                w_tick_raw;
    logic                w_tick;
    logic                w_zero;
    logic                w_ovf;
    logic [31:0]         w_rdata;
    logic                w_unused;

    // An access is the cycle that raises ack; the next cycle is forced idle
    assign w_sel        = stb_i & (adr_i[14:3] == BASE);
    assign w_acc        = w_sel & ~r_ack;
    assign w_wr         = w_acc & we_i;
    assign w_wr_ctrl    = w_wr & (adr_i[2:0] == OFF_CTRL);
    assign w_wr_reload  = w_wr & (adr_i[2:0] == OFF_RELOAD);
    assign w_wr_count   = w_wr & (adr_i[2:0] == OFF_COUNT);
    assign w_wr_compare = w_wr & (adr_i[2:0] == OFF_COMPARE);
    assign w_wr_status  = w_wr & (adr_i[2:0] == OFF_STATUS);

    // >= keeps the prescaler from running away if prescale is lowered mid-count
    assign w_tick_raw = r_en & (r_pre >= r_prescale);
    assign w_tick     = w_tick_raw & ~(w_wr_ctrl & ~dat_i[0]);
    assign w_zero     = (r_count == '0);
    assign w_ovf      = w_tick & w_zero;

    assign w_unused = ^dat_i;

    always_comb begin
        w_rdata = '0;
        case (adr_i[2:0])
            OFF_CTRL: begin
                w_rdata[0]             = r_en;
                w_rdata[1]             = r_ar;
                w_rdata[2]             = r_ie;
                w_rdata[8 +: PRE_BITS] = r_prescale;
            end
            OFF_RELOAD:  w_rdata[WIDTH-1:0] = r_reload;
            OFF_COUNT:   w_rdata[WIDTH-1:0] = r_count;
            OFF_COMPARE: w_rdata[WIDTH-1:0] = r_compare;
            OFF_STATUS:  w_rdata[0]         = r_ovf;
            default:     w_rdata            = '0;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_sel & ~r_ack;
            r_dat <= w_acc ? w_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_ar       <= 1'b0;
            r_ie       <= 1'b0;
            r_prescale <= '0;
            r_reload   <= '0;
            r_compare  <= '0;
        end else begin
            if (w_wr_ctrl) begin
                r_ar       <= dat_i[1];
                r_ie       <= dat_i[2];
                r_prescale <= dat_i[8 +: PRE_BITS];
            end
            if (w_wr_reload) begin
                r_reload <= dat_i[WIDTH-1:0];
            end
            if (w_wr_compare) begin
                r_compare <= dat_i[WIDTH-1:0];
            end
        end
    end

    // A CTRL write beats the one-shot hardware disable in the same cycle
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_en <= 1'b0;
        end else if (w_wr_ctrl) begin
            r_en <= dat_i[0];
        end else if (w_ovf & ~r_ar) begin
            r_en <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_pre <= '0;
        end else if (!r_en || w_tick_raw) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_BITS'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_count <= '0;
        end else if (w_wr_count) begin
            r_count <= dat_i[WIDTH-1:0];
        end else if (w_tick) begin
            if (!w_zero) begin
                r_count <= r_count - WIDTH'(1);
            end else if (r_ar) begin
                r_count <= r_reload;
            end
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_ovf <= 1'b0;
            r_irq <= 1'b0;
            r_pwm <= 1'b0;
        end else begin
            if (w_ovf) begin
                r_ovf <= 1'b1;
            end else if (w_wr_status & dat_i[0]) begin
                r_ovf <= 1'b0;
            end
            r_irq <= w_ovf & r_ie;
            r_pwm <= r_en & (r_count < r_compare);
        end
    end

    assign ack_o = r_ack;
    assign dat_o = r_dat;
    assign irq_o = r_irq;
    assign pwm_o = r_pwm;

endmodule

// File: tb/tb_wb_timer.sv
// tb/tb_wb_timer.sv - directed vector bench for wb_timer
module tb_wb_timer;

    localparam logic [11:0] BASE_T = 12'h000;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic [14:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        we_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        ack_o;
    logic        irq_o;
    logic        pwm_o;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int irq_cnt = 0;
    int last_e = 0;

    typedef struct {
        logic        we;
        logic [2:0]  off;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[15];

    wb_timer #(.WIDTH(24), .BASE(BASE_T), .PRE_BITS(8)) dut (
        .clk   (clk),
        .arst  (arst),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .stb_i (stb_i),
        .ack_o (ack_o),
        .irq_o (irq_o),
        .pwm_o (pwm_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (irq_o) irq_cnt <= irq_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Caller must be just past a negedge with stb_i low
    task automatic acc_now(input logic we, input logic [2:0] off, input logic [31:0] wd,
                           output logic [31:0] rd);
        int n;
        adr_i = {BASE_T, off};
        we_i  = we;
        dat_i = wd;
        stb_i = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ack_o && n < 8);
        if (!ack_o) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: offset %0d got ack 0 expected 1", off);
        end
        rd     = dat_o;
        last_e = cyc;
        @(negedge clk);
        stb_i = 1'b0;
        we_i  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] off, input logic [31:0] wd);
        logic [31:0] rd;
        @(negedge clk);
        acc_now(1'b1, off, wd, rd);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] off, input logic [31:0] exp);
        logic [31:0] rd;
        @(negedge clk);
        acc_now(1'b0, off, 32'd0, rd);
        chk(name, rd, exp);
    endtask

    task automatic align(input int m, input int r, input int e);
        do @(negedge clk); while (((cyc + 1 - e) % m) != r);
    endtask

    initial begin
        logic [31:0] rd;
        int e, k, highs, irq0;

        tbl[0]  = '{1'b1, 3'd0, 32'h0000_0AF6, 32'h0};
        tbl[1]  = '{1'b0, 3'd0, 32'h0,         32'h0000_0A06};
        tbl[2]  = '{1'b1, 3'd1, 32'hFFFF_FFFF, 32'h0};
        tbl[3]  = '{1'b0, 3'd1, 32'h0,         32'h00FF_FFFF};
        tbl[4]  = '{1'b1, 3'd2, 32'h1234_5678, 32'h0};
        tbl[5]  = '{1'b0, 3'd2, 32'h0,         32'h0034_5678};
        tbl[6]  = '{1'b1, 3'd3, 32'hABCD_EF01, 32'h0};
        tbl[7]  = '{1'b0, 3'd3, 32'h0,         32'h00CD_EF01};
        tbl[8]  = '{1'b0, 3'd4, 32'h0,         32'h0};
        tbl[9]  = '{1'b1, 3'd5, 32'hFFFF_FFFF, 32'h0};
        tbl[10] = '{1'b0, 3'd5, 32'h0,         32'h0};
        tbl[11] = '{1'b1, 3'd6, 32'hFFFF_FFFF, 32'h0};
        tbl[12] = '{1'b0, 3'd6, 32'h0,         32'h0};
        tbl[13] = '{1'b0, 3'd7, 32'h0,         32'h0};
        tbl[14] = '{1'b0, 3'd0, 32'h0,         32'h0000_0A06};

        #1;
        chk("rst_ack", {31'd0, ack_o}, 32'd0);
        chk("rst_dat", dat_o, 32'd0);
        chk("rst_irq", {31'd0, irq_o}, 32'd0);
        chk("rst_pwm", {31'd0, pwm_o}, 32'd0);
        @(negedge clk);
        arst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            acc_now(tbl[i].we, tbl[i].off, tbl[i].wd, rd);
            if (!tbl[i].we) chk($sformatf("vec%0d_off%0d", i, tbl[i].off), rd, tbl[i].exp);
        end

        // Held strobe: ack on edges 1 and 3 only
        @(negedge clk);
        adr_i = {BASE_T, 3'd1};
        stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("held_ack_%0d", i), {31'd0, ack_o}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        stb_i = 1'b0;
        @(negedge clk);
        adr_i = {12'h001, 3'd1};
        stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("nosel_ack_%0d", i), {31'd0, ack_o}, 32'd0);
        end
        @(negedge clk);
        stb_i = 1'b0;

        // Auto-reload with prescale 0
        wr(3'd1, 32'd3);
        wr(3'd2, 32'd3);
        wr(3'd4, 32'd1);
        wr(3'd0, 32'h007);
        e = last_e;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            k = cyc - e;
            chk($sformatf("ar_irq_k%0d", k), {31'd0, irq_o}, (k % 4 == 0) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            acc_now(1'b0, 3'd2, 32'd0, rd);
            k = last_e - 1 - e;
            chk($sformatf("ar_count_k%0d", k), rd, 32'(3 - (k % 4)));
        end
        rd_chk("ar_ovf_set", 3'd4, 32'd1);
        align(4, 2, e);
        acc_now(1'b1, 3'd4, 32'd1, rd);
        rd_chk("ar_ovf_cleared", 3'd4, 32'd0);
        align(4, 0, e);
        acc_now(1'b1, 3'd4, 32'd1, rd);
        rd_chk("coll_status_ovf", 3'd4, 32'd1);
        wr(3'd0, 32'h006);
        wr(3'd4, 32'd1);
        rd_chk("stop_ovf_clear", 3'd4, 32'd0);

        // One-shot, prescale 2, ie=0
        wr(3'd2, 32'd2);
        irq0 = irq_cnt;
        wr(3'd0, 32'h0201);
        e = last_e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            acc_now(1'b0, 3'd2, 32'd0, rd);
            k = last_e - 1 - e;
            chk($sformatf("os_count_k%0d", k), rd, (k < 3) ? 32'd2 : (k < 6) ? 32'd1 : 32'd0);
        end
        repeat (12) @(negedge clk);
        rd_chk("os_count_final", 3'd2, 32'd0);
        rd_chk("os_en_cleared", 3'd0, 32'h0000_0200);
        rd_chk("os_ovf", 3'd4, 32'd1);
        chk("os_no_irq", 32'(irq_cnt - irq0), 32'd0);

        // PWM: count 9..0 reloads, compare 3
        wr(3'd1, 32'd9);
        wr(3'd3, 32'd3);
        wr(3'd2, 32'd9);
        wr(3'd0, 32'h003);
        e = last_e;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            k = cyc - e;
            if (pwm_o) highs++;
            chk($sformatf("pwm_k%0d", k), {31'd0, pwm_o}, (((k - 1) % 10) >= 7) ? 32'd1 : 32'd0);
        end
        chk("pwm_duty", 32'(highs), 32'd6);
        wr(3'd3, 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("pwm_cmp0_%0d", i), {31'd0, pwm_o}, 32'd0);
        end

        // COUNT write on a tick edge, prescale 4
        wr(3'd2, 32'd100);
        wr(3'd0, 32'h0401);
        e = last_e;
        align(5, 0, e);
        acc_now(1'b1, 3'd2, 32'd50, rd);
        rd_chk("coll_count_w2", 3'd2, 32'd50);
        rd_chk("coll_count_w4", 3'd2, 32'd50);
        rd_chk("coll_count_w6", 3'd2, 32'd49);

        // Asynchronous reset mid-access
        wr(3'd3, 32'h00FF_FFFF);
        wr(3'd0, 32'h003);
        repeat (3) @(negedge clk);
        chk("pre_rst_pwm", {31'd0, pwm_o}, 32'd1);
        adr_i = {BASE_T, 3'd2};
        we_i  = 1'b0;
        stb_i = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_ack", {31'd0, ack_o}, 32'd1);
        arst = 1'b1;
        #1;
        chk("mid_rst_ack", {31'd0, ack_o}, 32'd0);
        chk("mid_rst_dat", dat_o, 32'd0);
        chk("mid_rst_irq", {31'd0, irq_o}, 32'd0);
        chk("mid_rst_pwm", {31'd0, pwm_o}, 32'd0);
        stb_i = 1'b0;
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_chk($sformatf("post_rst_off%0d", i), 3'(i), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wb_timer.md
Name: wb_timer

Overview:
- Wishbone slave peripheral on the MCU's Wishbone master port (adr/dat/we/stb/ack).
- Provides a prescaled down-counter with auto-reload, compare-driven PWM output and an overflow interrupt strobe.
- irq_o connects directly to one bit of the MCU irqs input; it is a one-cycle strobe, which the MCU latches as pending.

Parameters:
WIDTH, 24, counter/reload/compare width in bits (1..32)
BASE, 12'h000, block address; matches adr_i[14:3]
PRE_BITS, 8, prescaler width

Ports:
clk  input  1  system clock
arst  input  1  asynchronous reset, active-high
adr_i  input  15  Wishbone word address
dat_i  input  32  Wishbone write data
dat_o  output  32  Wishbone read data
we_i  input  1  1 = write, 0 = read
stb_i  input  1  strobe; held until ack
ack_o  output  1  acknowledge, one-cycle pulse
irq_o  output  1  overflow interrupt strobe
pwm_o  output  1  registered PWM output

Behaviour:
- Reset (arst=1, async): all registers 0. ack_o=0, dat_o=0, irq_o=0, pwm_o=0, prescaler=0.
- Decode: sel = stb_i & (adr_i[14:3]==BASE). Register offset = adr_i[2:0].
- Handshake: ack_o <= sel & ~ack_o, giving one wait state per access. No back-to-back ack; a strobe held after ack is re-acked only after one idle cycle. Non-selected strobes are never acked.
- Writes take effect on the edge that raises ack_o. dat_o is registered on that same edge, is valid while ack_o=1, and is 0 otherwise.
- Register map (unused bits read 0):
  - 0 CTRL: [0] en, [1] autoreload, [2] ie, [8+PRE_BITS-1:8] prescale.
  - 1 RELOAD: [WIDTH-1:0].
  - 2 COUNT: read gives the live value; write loads the counter.
  - 3 COMPARE: [WIDTH-1:0].
  - 4 STATUS: [0] ovf, sticky; write 1 clears.
  - 5-7: acked, read 0, writes ignored.
- Prescaler:
  - Counts 0..prescale while en=1; reaching prescale produces tick and returns to 0.
  - prescale=0 gives a tick every cycle.
  - en=0 holds the prescaler at 0.
- Counter on tick:
  - count!=0: count <= count-1.
  - count==0: ovf<=1; irq_o pulses 1 cycle (next cycle) if ie=1.
    - autoreload=1: count <= RELOAD.
    - autoreload=0: count stays 0 and en is cleared by hardware.
- pwm_o <= en & (count < COMPARE), registered with one cycle latency. COMPARE=0 gives constant 0. COMPARE > max count gives constant 1 while enabled.
- Write width: values wider than WIDTH are truncated.
- Simultaneous events:
  - Bus write to COUNT in the same cycle as a tick: the write wins, no decrement, and the prescaler is unaffected.
  - STATUS clear in the same cycle as an overflow: set wins, ovf=1.
  - Write to CTRL clearing en in a tick cycle: the tick is ignored.
  - Hardware en-clear and a CTRL write setting en in the same cycle: the write wins.
- Reset mid-access: ack_o drops immediately. The master must restart the transaction.

Test Plan:
- Reset: assert arst mid-count with stb_i high -> ack_o, irq_o, pwm_o and dat_o are 0 immediately; all registers read 0 afterward.
- Bus protocol:
  - Read offset 1 with stb held 4 cycles -> ack pulses in cycles 2 and 4 only.
  - Strobe with adr_i[14:3]!=BASE -> no ack.
  - Offset 6 -> acked, reads 0.
- Auto-reload:
  - Setup: RELOAD=3, COUNT=3, CTRL=0x007 (prescale 0).
  - Required: count sequence 3,2,1,0,3,2...; ovf set; irq_o pulses once every 4 cycles.
  - Write STATUS=1 -> ovf reads 0.
- One-shot with prescale:
  - Setup: COUNT=2, CTRL=0x0201 (prescale 2, no autoreload).
  - Required: decrements every 3 cycles; reaches 0; en reads 0; no irq (ie=0); ovf=1.
- PWM:
  - Setup: RELOAD=9, COMPARE=3, autoreload, prescale 0.
  - Required: pwm_o high 3 of every 10 cycles, lagging count by 1 cycle.
  - COMPARE=0 -> pwm_o stays low.
- Collisions:
  - COUNT write coincident with tick -> written value read back with no decrement.
  - STATUS clear coincident with overflow -> ovf reads 1.
